// File: rtl/bits_pkg.sv
// rtl/bits_pkg.sv - default parameters, clog2 helper and FSM states shared by bit_unpacker and bit_fifo
package bits_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_MAX_LEN = 15;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_fifo.sv
// rtl/bit_fifo.sv - word FIFO with first-word fall-through read; pushes while full are dropped
module bit_fifo
  import bits_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PTR_W  = clog2(DEPTH),
  parameter int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A push is refused whenever full, even if a pop frees a slot this cycle.
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/bit_unpacker.sv
// rtl/bit_unpacker.sv - bitstream unpacker top; BIT_UNPACKER_LSB_FIRST_EN selects LSB-first bit order
module bit_unpacker
  import bits_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pushin,
  input  logic [DATA_W-1:0]  datain,
  input  logic               reqin,
  input  logic [LEN_W-1:0]   reqlen,
  output logic               pushout,
  output logic [LEN_W-1:0]   lenout,
  output logic [MAX_LEN-1:0] dataout,
  output logic               busy,
  output logic               full,
  output logic               err
);

  localparam int ACC_W  = DATA_W + MAX_LEN;
  localparam int CNT_W  = clog2(ACC_W + 1);
  localparam int FCNT_W = clog2(DEPTH + 1);

  state_t             state;
  state_t             state_n;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_n;
  logic [ACC_W-1:0]   rem;
  logic [CNT_W-1:0]   acc_cnt;
  logic [CNT_W-1:0]   acc_cnt_n;
  logic [CNT_W-1:0]   rem_cnt;
  logic [CNT_W-1:0]   cons_cnt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   req_len;
  logic [LEN_W-1:0]   cons_len;
  logic               do_consume;
  logic               do_refill;
  logic [MAX_LEN-1:0] extract;
  logic [DATA_W-1:0]  fifo_data;
  logic               fifo_empty;
  logic [FCNT_W-1:0]  fifo_count;
  logic               unused_count;

  function automatic logic [ACC_W-1:0] low_mask(input logic [CNT_W-1:0] n);
    return (ACC_W'(1) << n) - ACC_W'(1);
  endfunction

  bit_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (pushin),
    .push_data (datain),
    .pop       (do_refill),
    .pop_data  (fifo_data),
    .full      (full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign unused_count = ^fifo_count;
  assign busy         = (state == WAIT);

  // A request that already fits is consumed on acceptance so pushout follows one cycle later.
  always_comb begin
    req_len    = ((LEN_W+1)'(reqlen) > (LEN_W+1)'(MAX_LEN)) ? LEN_W'(MAX_LEN) : reqlen;
    state_n    = state;
    do_consume = 1'b0;
    cons_len   = '0;
    case (state)
      IDLE: begin
        if (reqin) begin
          if (acc_cnt >= CNT_W'(req_len)) begin
            do_consume = 1'b1;
            cons_len   = req_len;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (acc_cnt >= CNT_W'(len_q)) begin
          do_consume = 1'b1;
          cons_len   = len_q;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Valid bits sit right-justified in acc; the oldest bits are at the top (MSB-first) or bottom (LSB-first).
  always_comb begin
    cons_cnt  = CNT_W'(cons_len);
    rem_cnt   = acc_cnt - cons_cnt;
    do_refill = (acc_cnt <= CNT_W'(MAX_LEN)) && !fifo_empty;
`ifdef BIT_UNPACKER_LSB_FIRST_EN
    extract = MAX_LEN'(acc & low_mask(cons_cnt));
    rem     = acc >> cons_cnt;
    acc_n   = do_refill ? (rem | (ACC_W'(fifo_data) << rem_cnt)) : rem;
`else
    extract = MAX_LEN'((acc >> rem_cnt) & low_mask(cons_cnt));
    rem     = acc & low_mask(rem_cnt);
    acc_n   = do_refill ? ((rem << DATA_W) | ACC_W'(fifo_data)) : rem;
`endif
    acc_cnt_n = rem_cnt + (do_refill ? CNT_W'(DATA_W) : '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      acc     <= '0;
      acc_cnt <= '0;
      len_q   <= '0;
      pushout <= 1'b0;
      lenout  <= '0;
      dataout <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      acc_cnt <= acc_cnt_n;
      if (state == IDLE && reqin) len_q <= req_len;
      pushout <= do_consume;
      if (do_consume) begin
        lenout  <= cons_len;
        dataout <= extract;
      end
      if (pushin && full) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bit_unpacker.sv
// tb/tb_bit_unpacker.sv - self-checking bench for bit_unpacker against a bit-queue stream model
module tb_bit_unpacker;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int MAX_LEN = 15;
  localparam int LEN_W   = 4;

  logic               clock  = 1'b0;
  logic               reset  = 1'b0;
  logic               pushin = 1'b0;
  logic [DATA_W-1:0]  datain = '0;
  logic               reqin  = 1'b0;
  logic [LEN_W-1:0]   reqlen = '0;
  logic               pushout;
  logic [LEN_W-1:0]   lenout;
  logic [MAX_LEN-1:0] dataout;
  logic               busy;
  logic               full;
  logic               err;

  int checks = 0;
  int errors = 0;
  bit stream_q[$];

  always #5 clock = ~clock;

  bit_unpacker #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .pushin  (pushin),
    .datain  (datain),
    .reqin   (reqin),
    .reqlen  (reqlen),
    .pushout (pushout),
    .lenout  (lenout),
    .dataout (dataout),
    .busy    (busy),
    .full    (full),
    .err     (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic append_word(input logic [DATA_W-1:0] w);
    for (int i = 0; i < DATA_W; i++) begin
`ifdef BIT_UNPACKER_LSB_FIRST_EN
      stream_q.push_back(w[i]);
`else
      stream_q.push_back(w[DATA_W-1-i]);
`endif
    end
  endtask

  task automatic take_bits(input int n, output logic [MAX_LEN-1:0] v);
    bit b;
    v = '0;
    for (int i = 0; i < n; i++) begin
      b = stream_q.pop_front();
`ifdef BIT_UNPACKER_LSB_FIRST_EN
      v[i] = b;
`else
      v = {v[MAX_LEN-2:0], b};
`endif
    end
  endtask

  task automatic push_one(input logic [DATA_W-1:0] w);
    @(negedge clock);
    pushin = 1'b1;
    datain = w;
    append_word(w);
    @(negedge clock);
    pushin = 1'b0;
  endtask

  task automatic xfer(input string tag, input int len, input int max_wait, output int lat);
    logic               got;
    logic [LEN_W-1:0]   olen;
    logic [MAX_LEN-1:0] odata;
    logic [MAX_LEN-1:0] exp;
    int                 eff;
    eff = (len > MAX_LEN) ? MAX_LEN : len;
    @(negedge clock);
    reqin  = 1'b1;
    reqlen = LEN_W'(len);
    @(negedge clock);
    reqin = 1'b0;
    lat   = 1;
    while (pushout !== 1'b1 && lat < max_wait) begin
      @(negedge clock);
      lat++;
    end
    got   = (pushout === 1'b1);
    olen  = lenout;
    odata = dataout;
    take_bits(eff, exp);
    check({tag, "_pushout"}, got, 1);
    check({tag, "_lenout"}, olen, eff);
    check({tag, "_dataout"}, odata, exp);
    @(negedge clock);
    check({tag, "_strobe"}, pushout, 0);
  endtask

  task automatic drain(input string tag);
    int lat;
    while (stream_q.size() > 0) begin
      xfer(tag, (stream_q.size() > MAX_LEN) ? MAX_LEN : stream_q.size(), 20, lat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int extra;
    int n;
    int len;
    logic [MAX_LEN-1:0] exp;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_pushout", pushout, 0);
    check("rst_lenout", lenout, 0);
    check("rst_dataout", dataout, 0);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_err", err, 0);
    reset = 1'b1;
    @(negedge clock);

    // Basic extract, zero-length request, drain
    push_one(32'hA5A50F0F);
    repeat (2) @(negedge clock);
    xfer("basic", 4, 10, lat);
    check("basic_lat", lat, 1);
    xfer("zero_len", 0, 10, lat);
    check("zero_len_lat", lat, 1);
    drain("basic_drain");

    // Cross-word extracts
    push_one(32'hFFFFFFFF);
    push_one(32'h00000000);
    repeat (2) @(negedge clock);
    xfer("cross_a", 15, 10, lat);
    xfer("cross_b", 15, 10, lat);
    xfer("cross_c", 4, 10, lat);
    drain("cross_drain");

    // Starvation with an ignored request while waiting
    @(negedge clock);
    reqin  = 1'b1;
    reqlen = 4'd8;
    @(negedge clock);
    reqin = 1'b0;
    check("starve_busy", busy, 1);
    check("starve_nopush", pushout, 0);
    reqin  = 1'b1;
    reqlen = 4'd3;
    @(negedge clock);
    reqin = 1'b0;
    check("starve_busy2", busy, 1);
    check("starve_nopush2", pushout, 0);
    pushin = 1'b1;
    datain = 32'h12345678;
    append_word(32'h12345678);
    @(negedge clock);
    pushin = 1'b0;
    lat = 0;
    while (pushout !== 1'b1 && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    take_bits(8, exp);
    check("starve_got", pushout, 1);
    check("starve_lat", lat <= 2, 1);
    check("starve_lenout", lenout, 8);
    check("starve_dataout", dataout, exp);
    @(negedge clock);
    check("starve_busy_clr", busy, 0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (pushout === 1'b1) extra++;
      @(negedge clock);
    end
    check("starve_no_extra", extra, 0);
    drain("starve_drain");

    // Overflow: one word goes to the accumulator, DEPTH words fill the FIFO
    check("pre_err", err, 0);
    for (int i = 0; i <= DEPTH; i++) begin
      @(negedge clock);
      if (i == DEPTH) check("not_full_yet", full, 0);
      pushin = 1'b1;
      datain = $urandom;
      append_word(datain);
    end
    @(negedge clock);
    pushin = 1'b0;
    check("full_set", full, 1);
    check("err_before_drop", err, 0);
    pushin = 1'b1;
    datain = 32'hDEADBEEF;
    @(negedge clock);
    pushin = 1'b0;
    check("err_set", err, 1);
    repeat (3) @(negedge clock);
    check("err_sticky", err, 1);
    drain("ovf_drain");
    check("err_after_drain", err, 1);
    check("full_after_drain", full, 0);

    // Reset asserted while waiting
    @(negedge clock);
    reqin  = 1'b1;
    reqlen = 4'd8;
    @(negedge clock);
    reqin = 1'b0;
    check("rw_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("rw_pushout", pushout, 0);
    check("rw_lenout", lenout, 0);
    check("rw_dataout", dataout, 0);
    check("rw_busy_clr", busy, 0);
    check("rw_full", full, 0);
    check("rw_err", err, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (pushout === 1'b1) extra++;
    end
    check("rw_no_pushout", extra, 0);
    stream_q.delete();
    push_one(32'hA5A50F0F);
    repeat (2) @(negedge clock);
    xfer("rw_basic", 4, 10, lat);
    check("rw_basic_lat", lat, 1);
    drain("rw_drain");

    // Randomized traffic
    for (int it = 0; it < 120; it++) begin
      n = $urandom_range(0, 2);
      if (stream_q.size() < 64) begin
        for (int k = 0; k < n; k++) push_one($urandom);
      end
      len = $urandom_range(0, MAX_LEN);
      while (stream_q.size() < len) push_one($urandom);
      xfer("rand", len, 20, lat);
    end
    drain("rand_drain");
    check("final_err", err, 0);
    check("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
